// File: rtl/la_rrmux.sv
//------------------------------------------------------------------------------
// la_rrmux : round-robin arbiter with AND-OR data select onto one valid/ready
//            channel. Optional output register stage: LA_RRMUX_OUTREG_EN.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module la_rrmux #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic [N-1:0]    gnt
);

  localparam int c_PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("la_rrmux: N must be in 2..16");
  end
  if (PROP == "") begin : g_bad_prop
    $error("la_rrmux: PROP must not be empty");
  end

  logic [c_PW-1:0] r_last;
  logic [N-1:0]    w_arb_gnt;
  logic [N-1:0]    w_gnt;
  logic [N-1:0]    w_xfer;
  logic [c_PW:0]   w_sum;
  logic            w_found;
  logic [c_PW-1:0] w_gnt_idx;
  logic [DW-1:0]   w_sel_data;

  // Scan lanes starting just after the last served one, wrapping modulo N.
  always_comb begin
    w_arb_gnt = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_last} + (c_PW+1)'(k);
      if (w_sum >= (c_PW+1)'(N)) w_sum = w_sum - (c_PW+1)'(N);
      if (!w_found && in_valid[w_sum[c_PW-1:0]]) begin
        w_arb_gnt[w_sum[c_PW-1:0]] = 1'b1;
        w_found                    = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) w_gnt_idx = w_gnt_idx | c_PW'(i);
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_data = w_sel_data | ({DW{w_gnt[i]}} & in_data[i*DW +: DW]);
    end
  end

  assign w_xfer = in_valid & in_ready;
  assign gnt    = w_gnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)      r_last <= c_PW'(N-1);
    else if (|w_xfer) r_last <= w_gnt_idx;
  end

`ifdef LA_RRMUX_OUTREG_EN
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            w_load;

  // The register itself holds a stalled beat, so grants only exist on load cycles.
  assign w_load    = ~r_out_valid | out_ready;
  assign w_gnt     = (nreset && w_load) ? w_arb_gnt : '0;
  assign in_ready  = w_gnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= |w_gnt;
      r_out_data  <= w_sel_data;
    end
  end
`else
  localparam logic [0:0] c_ARB  = 1'b0;
  localparam logic [0:0] c_HOLD = 1'b1;

  logic [0:0]   r_state;
  logic [N-1:0] r_gnt_q;

  // Outputs are forced quiet while reset is asserted, even with live requests.
  assign w_gnt     = nreset ? ((r_state == c_HOLD) ? r_gnt_q : w_arb_gnt) : '0;
  assign out_valid = |w_gnt;
  assign in_ready  = w_gnt & {N{out_ready}};
  assign out_data  = w_sel_data;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= c_ARB;
      r_gnt_q <= '0;
    end else begin
      case (r_state)
        c_ARB: begin
          if (out_valid && !out_ready) begin
            r_state <= c_HOLD;
            r_gnt_q <= w_arb_gnt;
          end
        end
        c_HOLD: begin
          if (out_ready) begin
            r_state <= c_ARB;
            r_gnt_q <= '0;
          end
        end
        default: begin
          r_state <= c_ARB;
          r_gnt_q <= '0;
        end
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_la_rrmux.sv
//------------------------------------------------------------------------------
// tb_la_rrmux : directed scoreboard bench for la_rrmux (N=4, DW=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_la_rrmux;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            nreset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [N-1:0]    gnt;

  int n_cmp;
  int n_bad;

  // Expected beats: {gnt nibble, data byte}
  logic [11:0] exp_q[$];

  la_rrmux #(.N(N), .DW(DW), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .gnt       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    exp_q.push_back(v);
  endtask

  // Monitor: every accepted beat must match the next expected one.
  always @(negedge clk) begin
    if (nreset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {20'h0, gnt, out_data}, 32'hFFF);
      end else begin
        chk("beat", {20'h0, gnt, out_data}, {20'h0, exp_q.pop_front()});
        chk("beat_in_ready", {28'h0, in_ready}, {28'h0, gnt});
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    nreset    = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    out_ready = 1'b1;

    // Reset with every lane requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready",  {28'h0, in_ready},  32'h0);
    chk("rst_gnt",       {28'h0, gnt},       32'h0);
    chk("rst_out_data",  {24'h0, out_data},  32'h0);
    cyc();
    nreset = 1'b1;

    // Strict rotation starting at lane 0
    push(12'h110); push(12'h221); push(12'h432); push(12'h843); push(12'h110);
    repeat (5) cyc();

    // Idle
    in_valid = 4'b0000;
    @(negedge clk);
    chk("idle_gnt",       {28'h0, gnt},       32'h0);
    chk("idle_out_valid", {31'h0, out_valid}, 32'h0);
    chk("idle_out_data",  {24'h0, out_data},  32'h0);
    cyc();

    // Stall: lane 2 held while lanes 0 and 1 join (last = 0)
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_arb_gnt", {28'h0, gnt}, 32'h4);
    cyc();
    in_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_gnt",      {28'h0, gnt},      32'h4);
      chk("stall_out_data", {24'h0, out_data}, 32'h32);
      chk("stall_in_ready", {28'h0, in_ready}, 32'h0);
      cyc();
    end
    out_ready = 1'b1;
    push(12'h432);
    cyc();
    in_valid = 4'b0011;
    push(12'h110);
    cyc();
    in_valid = 4'b0010;
    push(12'h221);
    cyc();

    // Sparse requests and wrap
    in_valid = 4'b1000; push(12'h843); cyc();
    in_valid = 4'b0010; push(12'h221); cyc();
    in_valid = 4'b0101; push(12'h432); cyc();
    in_valid = 4'b0001; push(12'h110); cyc();
    in_valid = 4'b0000;

    // Reset while lane 1 is held
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    cyc();
    nreset = 1'b0;
    #1;
    chk("mrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mrst_gnt",       {28'h0, gnt},       32'h0);
    chk("mrst_in_ready",  {28'h0, in_ready},  32'h0);
    chk("mrst_out_data",  {24'h0, out_data},  32'h0);
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    cyc();
    nreset = 1'b1;
    push(12'h110);
    cyc();
    in_valid = 4'b0010;
    push(12'h221);
    cyc();
    in_valid = 4'b0000;

    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
